// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-port register file.
package rf_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_clr_state_e;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_DEPTH_DEF = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback or clear sweep,
// looked up once per read port.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH    = RF_DEPTH_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_vld_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              wb_vld_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic              sweep_vld_i,
    input  logic [AW-1:0]     sweep_addr_i,
    input  logic [AW-1:0]     raddr_i [NUM_RD],
    output logic [NUM_RD-1:0] pend_o
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Set is applied last so a newer producer issued in the same cycle as
    // the older one's writeback keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_vld_i) begin
            pending_d[wb_addr_i] = 1'b0;
        end
        if (sweep_vld_i) begin
            pending_d[sweep_addr_i] = 1'b0;
        end
        if (set_vld_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        pend_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            pend_o[i] = pending_q[raddr_i[i]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, write bypass, pending
// scoreboard and a one-entry-per-cycle bulk clear sequencer.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter  int XLEN     = RF_XLEN_DEF,
    parameter  int DEPTH    = RF_DEPTH_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [AW-1:0]     raddr [NUM_RD],
    output logic [XLEN-1:0]   rdata [NUM_RD],
    output logic [NUM_RD-1:0] rbusy,
    input  logic              mark_vld,
    input  logic [AW-1:0]     mark_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    rf_clr_state_e    state_q;
    logic [AW-1:0]    idx_q;
    logic             clr_busy_q;
    logic [XLEN-1:0]  regs_q [DEPTH];

    logic              idle;
    logic              wr_ok;
    logic              mark_ok;
    logic              sweep;
    logic [NUM_RD-1:0] pend;

    assign idle    = (state_q == RF_IDLE);
    assign sweep   = !idle;
    assign wr_ok   = idle && reg_wr && !((ZERO_REG != 0) && (waddr == '0));
    assign mark_ok = idle && mark_vld && !((ZERO_REG != 0) && (mark_addr == '0));

    // Clear sequencer: one entry per cycle, exits after the last index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RF_IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_q    <= RF_CLEAR;
                        idx_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_q    <= RF_IDLE;
                        idx_q      <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else if (sweep) begin
            regs_q[idx_q] <= '0;
        end else if (wr_ok) begin
            regs_q[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_vld_i    (mark_ok),
        .set_addr_i   (mark_addr),
        .wb_vld_i     (wr_ok),
        .wb_addr_i    (waddr),
        .sweep_vld_i  (sweep),
        .sweep_addr_i (idx_q),
        .raddr_i      (raddr),
        .pend_o       (pend)
    );

    // wr_ok already excludes the clear sweep and the hardwired zero register.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdata[i] = regs_q[raddr[i]];
            rbusy[i] = pend[i];
            if ((ZERO_REG != 0) && (raddr[i] == '0)) begin
                rdata[i] = '0;
            end
            if ((BYPASS != 0) && wr_ok && (waddr == raddr[i])) begin
                rdata[i] = wdata;
                rbusy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default instance against an array/queue
// model, plus a 4-port no-bypass 16-entry instance.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];
    logic [1:0]  rbusy;
    logic        mark_vld;
    logic [4:0]  mark_addr;
    logic        clr_req;
    logic        clr_busy;

    logic        reg_wr2;
    logic [3:0]  waddr2;
    logic [31:0] wdata2;
    logic [3:0]  raddr2 [4];
    logic [31:0] rdata2 [4];
    logic [3:0]  rbusy2;
    logic        mark_vld2;
    logic [3:0]  mark_addr2;
    logic        clr_req2;
    logic        clr_busy2;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    bit          m_pend [32];
    int          m_clr_left;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .mark_vld(mark_vld),
        .mark_addr(mark_addr), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    reg_file_mp #(.XLEN(32), .DEPTH(16), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr2), .waddr(waddr2), .wdata(wdata2),
        .raddr(raddr2), .rdata(rdata2), .rbusy(rbusy2), .mark_vld(mark_vld2),
        .mark_addr(mark_addr2), .clr_req(clr_req2), .clr_busy(clr_busy2)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_clr_left == 0 && reg_wr && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (m_clr_left == 0 && reg_wr && waddr == a && a != 5'd0) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_wipe();
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = 32'h0;
            m_pend[k] = 1'b0;
        end
        m_clr_left = 0;
    endtask

    task automatic idle_inputs();
        reg_wr = 0; waddr = 0; wdata = 0; mark_vld = 0; mark_addr = 0; clr_req = 0;
        raddr[0] = 0; raddr[1] = 0;
        reg_wr2 = 0; waddr2 = 0; wdata2 = 0; mark_vld2 = 0; mark_addr2 = 0; clr_req2 = 0;
        for (int i = 0; i < 4; i++) raddr2[i] = 0;
    endtask

    // Advance one clock and apply the architectural effect of the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (m_clr_left > 0) begin
            m_clr_left--;
            if (m_clr_left == 0) model_wipe();
        end else begin
            if (reg_wr && waddr != 0) begin
                m_reg[waddr]  = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (mark_vld && mark_addr != 0) m_pend[mark_addr] = 1'b1;
            if (clr_req) m_clr_left = 32;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_wipe();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(31 - a);
            #1;
            for (int p = 0; p < 2; p++) begin
                n_vec++;
                if (rdata[p] !== 32'h0 || rbusy[p] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_read addr %0d port %0d: got %h busy %b, expected 0 busy 0",
                             raddr[p], p, rdata[p], rbusy[p]);
                end
            end
        end
        n_vec++;
        if (clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clr_busy: got %b expected 0", clr_busy);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        reg_wr = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr[0] = 5; raddr[1] = 0;
        #1;
        n_vec++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h expected deadbeef", rdata[0]);
        end
        tick();
        @(negedge clk);
        reg_wr = 0;
        #1;
        n_vec++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_after_write: got %h expected deadbeef", rdata[0]);
        end
        reg_wr = 1; waddr = 0; wdata = 32'h1234; raddr[0] = 0;
        #1;
        n_vec++;
        if (rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL zero_reg_bypass: got %h expected 0", rdata[0]);
        end
        tick();
        @(negedge clk);
        reg_wr = 0;
        #1;
        n_vec++;
        if (rdata[0] !== 32'h0) begin
            n_err++;
            $display("FAIL zero_reg_write: got %h expected 0", rdata[0]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        mark_vld = 1; mark_addr = 7; raddr[0] = 7;
        tick();
        @(negedge clk);
        mark_vld = 0;
        #1;
        n_vec++;
        if (rbusy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_marked: got %b expected 1", rbusy[0]);
        end
        reg_wr = 1; waddr = 7; wdata = 32'h55;
        #1;
        n_vec++;
        if (rbusy[0] !== 1'b0 || rdata[0] !== 32'h55) begin
            n_err++;
            $display("FAIL sb_bypass_clear: got busy %b data %h expected busy 0 data 55", rbusy[0], rdata[0]);
        end
        tick();
        @(negedge clk);
        reg_wr = 0;
        #1;
        n_vec++;
        if (rbusy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_cleared: got %b expected 0", rbusy[0]);
        end
        reg_wr = 1; waddr = 7; wdata = 32'h66; mark_vld = 1; mark_addr = 7;
        tick();
        @(negedge clk);
        reg_wr = 0; mark_vld = 0;
        #1;
        n_vec++;
        if (rbusy[0] !== 1'b1 || rdata[0] !== 32'h66) begin
            n_err++;
            $display("FAIL sb_set_wins: got busy %b data %h expected busy 1 data 66", rbusy[0], rdata[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            reg_wr    = 1'($urandom);
            waddr     = 5'($urandom);
            wdata     = $urandom;
            mark_vld  = ($urandom_range(0, 2) == 0);
            mark_addr = 5'($urandom);
            raddr[0]  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr[1]  = ($urandom_range(0, 3) == 0) ? mark_addr : 5'($urandom);
            #1;
            for (int p = 0; p < 2; p++) begin
                n_vec++;
                if (rdata[p] !== exp_rd(raddr[p]) || rbusy[p] !== exp_busy(raddr[p])) begin
                    n_err++;
                    $display("FAIL rand_read cyc %0d port %0d addr %0d: got %h busy %b, expected %h busy %b",
                             c, p, raddr[p], rdata[p], rbusy[p], exp_rd(raddr[p]), exp_busy(raddr[p]));
                end
            end
            tick();
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic check_all_model(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(a) ^ 5'h1f;
            #1;
            for (int p = 0; p < 2; p++) begin
                n_vec++;
                if (rdata[p] !== exp_rd(raddr[p]) || rbusy[p] !== exp_busy(raddr[p])) begin
                    n_err++;
                    $display("FAIL %s addr %0d port %0d: got %h busy %b, expected %h busy %b",
                             tag, raddr[p], p, rdata[p], rbusy[p], exp_rd(raddr[p]), exp_busy(raddr[p]));
                end
            end
        end
    endtask

    task automatic test_clear();
        int cnt;
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            reg_wr = 1; waddr = 5'(a); wdata = $urandom | 32'h1;
            mark_vld = (a % 3 == 0); mark_addr = 5'(a);
            tick();
        end
        @(negedge clk);
        reg_wr = 1; waddr = 31; wdata = 32'hC0FFEE01; mark_vld = 0; clr_req = 1;
        #1;
        n_vec++;
        if (clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_busy_early: got %b expected 0", clr_busy);
        end
        tick();
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cnt < 28) begin
                reg_wr = 1; waddr = 5'($urandom); wdata = $urandom;
                mark_vld = 1; mark_addr = 5'($urandom); clr_req = (cnt < 20);
            end else begin
                idle_inputs();
            end
            if (cnt == 0) begin
                waddr = 31; raddr[0] = 31;
                #1;
                n_vec++;
                if (rdata[0] !== 32'hC0FFEE01) begin
                    n_err++;
                    $display("FAIL clr_write_before_sweep: got %h expected c0ffee01", rdata[0]);
                end
            end
            #1;
            if (!clr_busy) break;
            cnt++;
            tick();
        end
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL clr_busy_len: got %0d cycles expected 32", cnt);
        end
        idle_inputs();
        check_all_model("clr_after");
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            reg_wr = 1; waddr = 5'(a); wdata = 32'hA000_0000 | 32'(a);
            mark_vld = 1; mark_addr = 5'(a ^ 1);
            tick();
        end
        @(negedge clk);
        idle_inputs();
        clr_req = 1;
        tick();
        @(negedge clk);
        clr_req = 0;
        repeat (10) tick();
        @(negedge clk);
        rst_n = 1'b0;
        model_wipe();
        #1;
        n_vec++;
        if (clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_clr_busy: got %b expected 0", clr_busy);
        end
        check_all_model("rst_mid_clr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_req = 1;
        tick();
        @(negedge clk);
        clr_req = 0;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!clr_busy) break;
            cnt++;
            tick();
            @(negedge clk);
        end
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL rst_then_clr_len: got %0d cycles expected 32", cnt);
        end
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        reg_wr2 = 1; waddr2 = 3; wdata2 = 32'hA5;
        for (int i = 0; i < 4; i++) raddr2[i] = 3;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rdata2[i] !== 32'h0) begin
                n_err++;
                $display("FAIL nobyp_old port %0d: got %h expected 0", i, rdata2[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reg_wr2 = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rdata2[i] !== 32'hA5) begin
                n_err++;
                $display("FAIL nobyp_new port %0d: got %h expected a5", i, rdata2[i]);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_bypass();
        test_scoreboard();
        test_random();
        test_clear();
        test_reset_mid_clear();
        do_reset();
        test_no_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
